// File: rtl/seg_pattern_reader_if.sv
// rtl/seg_pattern_reader_if.sv - segment pattern bus and frame handshake bundle for seg_pattern_reader
interface seg_pattern_reader_if #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 2
);
  // Time-multiplexed display side: active-low pattern, hex[0]=a .. hex[6]=g
  logic [0:6]              hex;
  logic [IDX_W-1:0]        idx;

  // Frame consumer side
  logic                    ack;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    err;
  logic                    valid;
  logic                    overrun;

  // Master drives the display bus and acknowledges frames
  modport master (
    output hex, idx, ack,
    input  value, blank, err, valid, overrun
  );

  // Slave is the reader: samples the display bus and presents frames
  modport slave (
    input  hex, idx, ack,
    output value, blank, err, valid, overrun
  );
endinterface

// File: rtl/seg_pattern_reader.sv
// rtl/seg_pattern_reader.sv - seven-segment pattern reader assembling BCD frames with valid/ack handoff
module seg_pattern_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int IDX_W         = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  seg_pattern_reader_if.slave bus
);

  // Counter saturates at STABLE_CYCLES; the accept fires on the step into it
  localparam logic [7:0] CNT_SAT    = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_ACCEPT = 8'(STABLE_CYCLES - 1);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Two-deep sample pipeline: samp_* is the registered bus, prev_* the one before
  logic [0:6]              samp_hex_q, prev_hex_q;
  logic [IDX_W-1:0]        samp_idx_q, prev_idx_q;
  logic [7:0]              cnt_q, cnt_d;
  logic                    same;
  logic                    accept;

  // Decoded digit of the stable sample
  logic [0:6]              seg;
  logic [3:0]              dec_val;
  logic                    dec_blank;
  logic                    dec_ill;

  // Working frame being collected
  logic [NUM_DIGITS-1:0]   sel;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] work_val_q;
  logic [NUM_DIGITS-1:0]   work_blank_q;
  logic [NUM_DIGITS-1:0]   work_ill_q;
  logic                    mask_full;

  // Presented frame
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic                    err_q;
  logic                    overrun_q;

  // FSM control strobes
  logic                    load_frame;
  logic                    clear_mask;
  logic                    set_ovr;
  logic                    clr_ovr;

  // Stability counter: count identical consecutive samples, restart on any change
  always_comb begin
    same  = (samp_hex_q == prev_hex_q) && (samp_idx_q == prev_idx_q);
    cnt_d = cnt_q;
    if (!same) begin
      cnt_d = 8'd1;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + 8'd1;
    end
    accept = same && (cnt_q == CNT_ACCEPT);
  end

  // Decode the inverted pattern (abcdefg) to BCD, blank or illegal
  always_comb begin
    seg       = ~prev_hex_q;
    dec_val   = 4'hE;
    dec_blank = 1'b0;
    dec_ill   = 1'b0;
    case (seg)
      7'b1111110: dec_val = 4'd0;
      7'b0110000: dec_val = 4'd1;
      7'b1101101: dec_val = 4'd2;
      7'b1111001: dec_val = 4'd3;
      7'b0110011: dec_val = 4'd4;
      7'b1011011: dec_val = 4'd5;
      7'b1011111: dec_val = 4'd6;
      7'b1110000: dec_val = 4'd7;
      7'b1111111: dec_val = 4'd8;
      7'b1111011: dec_val = 4'd9;
      7'b0000000: begin
        dec_val   = 4'hF;
        dec_blank = 1'b1;
      end
      default: begin
        dec_val = 4'hE;
        dec_ill = 1'b1;
      end
    endcase
  end

  // Slot select for an accepted digit; indices past the frame match no slot
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (accept && (prev_idx_q == IDX_W'(i))) begin
        sel[i] = 1'b1;
      end
    end
    mask_full = &mask_q;
    mask_d    = (clear_mask ? '0 : mask_q) | sel;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and frame-handoff strobes
  always_comb begin
    state_d    = state_q;
    load_frame = 1'b0;
    clear_mask = 1'b0;
    set_ovr    = 1'b0;
    clr_ovr    = 1'b0;
    case (state_q)
      S_COLLECT: begin
        if (mask_full) begin
          load_frame = 1'b1;
          clear_mask = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.ack) begin
          clr_ovr = 1'b1;
          if (mask_full) begin
            // Pending frame replaces the acknowledged one without a gap
            load_frame = 1'b1;
            clear_mask = 1'b1;
          end else begin
            state_d = S_COLLECT;
          end
        end else if (mask_full) begin
          // Consumer still holds the old frame: drop the new one
          clear_mask = 1'b1;
          set_ovr    = 1'b1;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // Sampling pipeline, working frame capture and presented frame registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      samp_hex_q   <= '0;
      samp_idx_q   <= '0;
      prev_hex_q   <= '0;
      prev_idx_q   <= '0;
      cnt_q        <= '0;
      mask_q       <= '0;
      work_val_q   <= '0;
      work_blank_q <= '0;
      work_ill_q   <= '0;
      value_q      <= '0;
      blank_q      <= '0;
      err_q        <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      samp_hex_q <= bus.hex;
      samp_idx_q <= bus.idx;
      prev_hex_q <= samp_hex_q;
      prev_idx_q <= samp_idx_q;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel[i]) begin
          work_val_q[4*i +: 4] <= dec_val;
          work_blank_q[i]      <= dec_blank;
          work_ill_q[i]        <= dec_ill;
        end
      end
      if (load_frame) begin
        value_q <= work_val_q;
        blank_q <= work_blank_q;
        err_q   <= |work_ill_q;
      end
      if (set_ovr) begin
        overrun_q <= 1'b1;
      end else if (clr_ovr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.value   = value_q;
  assign bus.blank   = blank_q;
  assign bus.err     = err_q;
  assign bus.valid   = (state_q == S_HOLD);
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_seg_pattern_reader.sv
// tb/tb_seg_pattern_reader.sv - directed self-checking bench for seg_pattern_reader
module tb_seg_pattern_reader;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seg_pattern_reader_if #(.NUM_DIGITS(4), .IDX_W(2)) bus_a ();
  seg_pattern_reader_if #(.NUM_DIGITS(3), .IDX_W(2)) bus_b ();

  seg_pattern_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(8), .IDX_W(2)) u_dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a.slave)
  );

  seg_pattern_reader #(.NUM_DIGITS(3), .STABLE_CYCLES(8), .IDX_W(2)) u_dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b.slave)
  );

  // Active-low patterns, a..g left to right
  localparam logic [6:0] H0 = 7'b0000001;
  localparam logic [6:0] H1 = 7'b1001111;
  localparam logic [6:0] H2 = 7'b0010010;
  localparam logic [6:0] H3 = 7'b0000110;
  localparam logic [6:0] H4 = 7'b1001100;
  localparam logic [6:0] H5 = 7'b0100100;
  localparam logic [6:0] H6 = 7'b0100000;
  localparam logic [6:0] H7 = 7'b0001111;
  localparam logic [6:0] H8 = 7'b0000000;
  localparam logic [6:0] H9 = 7'b0000100;
  localparam logic [6:0] HB = 7'b1111111;
  localparam logic [6:0] HX = 7'b0110110;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_a(input logic [6:0] h, input logic [1:0] i, input int n);
    bus_a.hex = h;
    bus_a.idx = i;
    step(n);
  endtask

  task automatic put_b(input logic [6:0] h, input logic [1:0] i, input int n);
    bus_b.hex = h;
    bus_b.idx = i;
    step(n);
  endtask

  task automatic ack_a();
    bus_a.ack = 1'b1;
    step(1);
    bus_a.ack = 1'b0;
  endtask

  task automatic frame_a(input logic [6:0] h0, input logic [6:0] h1,
                         input logic [6:0] h2, input logic [6:0] h3);
    put_a(h0, 2'd0, 10);
    put_a(h1, 2'd1, 10);
    put_a(h2, 2'd2, 10);
    put_a(h3, 2'd3, 10);
  endtask

  initial begin
    rst       = 1'b1;
    bus_a.hex = HB;
    bus_a.idx = 2'd0;
    bus_a.ack = 1'b0;
    bus_b.hex = HB;
    bus_b.idx = 2'd3;
    bus_b.ack = 1'b0;
    step(2);
    chk("rst_value",   bus_a.value,   32'h0);
    chk("rst_blank",   bus_a.blank,   32'h0);
    chk("rst_err",     bus_a.err,     32'h0);
    chk("rst_valid",   bus_a.valid,   32'h0);
    chk("rst_overrun", bus_a.overrun, 32'h0);
    chk("rst_valid_b", bus_b.valid,   32'h0);
    rst = 1'b0;

    // Basic frame 1,2,3,4 with exact completion timing
    put_a(H1, 2'd0, 10);
    put_a(H2, 2'd1, 10);
    put_a(H3, 2'd2, 10);
    put_a(H4, 2'd3, 9);
    chk("basic_valid_early", bus_a.valid, 32'h0);
    step(1);
    chk("basic_valid", bus_a.valid, 32'h1);
    chk("basic_value", bus_a.value, 32'h4321);
    chk("basic_blank", bus_a.blank, 32'h0);
    chk("basic_err",   bus_a.err,   32'h0);
    ack_a();
    chk("basic_ack_valid", bus_a.valid, 32'h0);
    chk("basic_hold_value", bus_a.value, 32'h4321);

    // Glitch on slot 0 shorter than the stability window, then 0,9,blank,5
    put_a(H0, 2'd0, 10);
    put_a(H8, 2'd0, 7);
    put_a(H0, 2'd0, 10);
    put_a(H9, 2'd1, 10);
    put_a(HB, 2'd2, 10);
    put_a(H5, 2'd3, 10);
    chk("glitch_valid", bus_a.valid, 32'h1);
    chk("glitch_value", bus_a.value, 32'h5F90);
    chk("glitch_blank", bus_a.blank, 32'h4);
    chk("glitch_err",   bus_a.err,   32'h0);
    ack_a();

    // Remaining digits 8,6,7 and a blank in the top slot
    frame_a(H8, H6, H7, HB);
    chk("sweep_value", bus_a.value, 32'hF768);
    chk("sweep_blank", bus_a.blank, 32'h8);
    ack_a();

    // Illegal pattern on slot 2
    frame_a(H5, H6, HX, H7);
    chk("illegal_valid", bus_a.valid, 32'h1);
    chk("illegal_value", bus_a.value, 32'h7E65);
    chk("illegal_err",   bus_a.err,   32'h1);
    chk("illegal_blank", bus_a.blank, 32'h0);

    // Reset with a frame held and three digits of the next one collected
    put_a(H1, 2'd0, 10);
    put_a(H2, 2'd1, 10);
    put_a(H3, 2'd2, 10);
    rst       = 1'b1;
    bus_a.hex = H4;
    bus_a.idx = 2'd3;
    step(2);
    rst = 1'b0;
    chk("midrst_value",   bus_a.value,   32'h0);
    chk("midrst_err",     bus_a.err,     32'h0);
    chk("midrst_valid",   bus_a.valid,   32'h0);
    chk("midrst_overrun", bus_a.overrun, 32'h0);
    step(20);
    chk("midrst_one_digit", bus_a.valid, 32'h0);
    put_a(H1, 2'd0, 10);
    put_a(H2, 2'd1, 10);
    put_a(H3, 2'd2, 9);
    chk("midrst_not_yet", bus_a.valid, 32'h0);
    step(1);
    chk("midrst_valid_after", bus_a.valid, 32'h1);
    chk("midrst_value_after", bus_a.value, 32'h4321);
    ack_a();

    // Overrun: second frame completes while first unacknowledged
    frame_a(H1, H2, H3, H4);
    chk("ovr_first_valid", bus_a.valid,   32'h1);
    chk("ovr_first_flag",  bus_a.overrun, 32'h0);
    frame_a(H5, H6, H7, H8);
    chk("ovr_valid",  bus_a.valid,   32'h1);
    chk("ovr_value",  bus_a.value,   32'h4321);
    chk("ovr_flag",   bus_a.overrun, 32'h1);
    ack_a();
    chk("ovr_ack_valid", bus_a.valid,   32'h0);
    chk("ovr_ack_flag",  bus_a.overrun, 32'h0);

    // Ack lands in the same cycle the next frame fills
    frame_a(H1, H2, H3, H4);
    put_a(H9, 2'd0, 10);
    put_a(H8, 2'd1, 10);
    put_a(H7, 2'd2, 10);
    put_a(H6, 2'd3, 9);
    chk("simul_old_value", bus_a.value, 32'h4321);
    bus_a.ack = 1'b1;
    step(1);
    bus_a.ack = 1'b0;
    chk("simul_valid",   bus_a.valid,   32'h1);
    chk("simul_value",   bus_a.value,   32'h6789);
    chk("simul_overrun", bus_a.overrun, 32'h0);
    ack_a();
    chk("simul_ack_valid", bus_a.valid, 32'h0);

    // Ack while nothing is presented
    ack_a();
    step(2);
    chk("idle_ack_valid", bus_a.valid, 32'h0);
    chk("idle_ack_value", bus_a.value, 32'h6789);

    // Three-digit reader: index 3 ignored, repeated slot 0 keeps the last value
    put_b(H1, 2'd3, 20);
    put_b(H2, 2'd0, 10);
    put_b(H3, 2'd0, 10);
    put_b(H4, 2'd1, 10);
    put_b(H5, 2'd3, 10);
    chk("b_partial_valid", bus_b.valid, 32'h0);
    put_b(H6, 2'd2, 10);
    chk("b_valid", bus_b.valid, 32'h1);
    chk("b_value", bus_b.value, 32'h643);
    chk("b_blank", bus_b.blank, 32'h0);
    chk("b_err",   bus_b.err,   32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/seg_pattern_reader.md
Name: seg_pattern_reader

Overview:
- Reader for the team's active-low seven-segment displays. It samples a time-multiplexed HEX pattern bus, qualifies each pattern as stable, and decodes it back to a BCD digit or blank.
- It assembles one frame of NUM_DIGITS digits and hands the frame to a consumer with a Valid/Ack handshake.
- Used by self-checking display benches and by the display loopback path on the board.

Parameters:
- NUM_DIGITS, 4, digits per frame (1..8).
- STABLE_CYCLES, 8, consecutive identical samples required before a pattern is accepted (2..255).
- IDX_W, 2, width of the digit-index input; 2**IDX_W >= NUM_DIGITS.

Ports:
- Clock, input, 1, system clock; all state updates on the rising edge.
- Reset, input, 1, synchronous, active-high; sampled on the rising edge of Clock.
- HEX, input, [0:6], active-low segment pattern; HEX[0]=a through HEX[6]=g.
- Idx, input, IDX_W, index of the digit currently driven on HEX.
- Ack, input, 1, consumer accepts the presented frame.
- Value, output, 4*NUM_DIGITS, BCD frame; digit i occupies bits [4i+3:4i].
- Blank, output, NUM_DIGITS, bit i set means digit i was all-off.
- Err, output, 1, at least one digit in the frame had an illegal pattern.
- Valid, output, 1, frame present on Value/Blank/Err.
- Overrun, output, 1, a frame completed while the previous frame was still unacknowledged.

Behaviour:
- Reset values: Value=0, Blank=0, Err=0, Valid=0, Overrun=0. Internal capture mask, stability counter and sample registers are also cleared. Reset takes priority over every other event and aborts any partial frame or held frame.
- Sampling: {HEX, Idx} is registered every cycle. The stability counter increments while the registered sample equals the previous one, saturating at STABLE_CYCLES, and reloads to 1 on any change.
- Accept: a pattern is accepted exactly once, on the cycle the counter reaches STABLE_CYCLES. It is not accepted again until {HEX, Idx} changes and re-stabilises.
- Earliest accept: STABLE_CYCLES+1 clocks after the input first presents the pattern.
- Out-of-range index: Idx >= NUM_DIGITS is ignored and never accepted.
- Decode: the inverted pattern ~HEX, read as abcdefg, maps as follows.
  - 1111110 -> 0
  - 0110000 -> 1
  - 1101101 -> 2
  - 1111001 -> 3
  - 0110011 -> 4
  - 1011011 -> 5
  - 1011111 -> 6
  - 1110000 -> 7
  - 1111111 -> 8
  - 1111011 -> 9
  - 0000000 -> blank: digit value 4'hF, Blank bit set.
  - Any other pattern -> illegal: digit value 4'hE, Blank bit clear, frame error flag set.
- Capture: an accepted digit is written to the working slot selected by Idx and sets that mask bit. If the slot is already captured, the newer value overwrites it and the mask is unchanged.
- State COLLECT:
  - When the mask becomes all-ones, the working frame and its error flag are copied to Value/Blank/Err on the next edge.
  - On that same edge Valid is set, the mask clears and the state moves to HOLD.
- State HOLD:
  - Value, Blank, Err and Valid stay constant until Ack is sampled high.
  - On that edge Valid clears; if a completed working frame is already pending, it is loaded instead and Valid stays 1.
  - Collection continues into the working registers while in HOLD.
  - If the working mask fills while Valid=1 and Ack=0, that frame is dropped, Overrun sets, the mask clears and collection restarts.
- Ack with Valid=0 has no effect.
- Simultaneous Ack and mask-full in the same cycle: the new frame is loaded with Valid=1, it is not an overrun, and the state stays HOLD.
- Overrun clears only on an edge where Ack=1 and Valid=1, or on Reset.
- No combinational path exists from any input to any output.

Test Plan:
- Reset: assert Reset for 2 cycles mid-frame after 3 of 4 digits have been captured. Required: all outputs 0 and the mask empty; a fresh 4-digit frame is then needed before Valid rises.
- Basic frame: drive digits 1,2,3,4 on Idx 0..3 (HEX=1001111, 0010010, 0000110, 1001100), each held 10 cycles. Required: Value=16'h4321, Blank=0, Err=0, Valid=1 two cycles after the last accept; Ack clears Valid the next cycle.
- Stability and all patterns:
  - Glitch HEX for 7 cycles (STABLE_CYCLES-1), then restore it. Required: no accept occurs.
  - Sweep all 10 digits plus blank (HEX=1111111). Required: the blank digit reads 4'hF with its Blank bit set.
- Illegal pattern: HEX=0110110 on Idx 2 within a frame of otherwise legal digits 5,6,7. Required: Value=16'h7E65 and Err=1.
- Overrun and simultaneity:
  - Hold Ack low while two frames complete. Required: the first frame is retained and Overrun=1; Ack clears both Valid and Overrun.
  - Repeat with Ack asserted in the mask-full cycle. Required: the second frame is loaded, Valid stays 1 and Overrun stays 0.
- Ignored index: Idx=3 with NUM_DIGITS=3, plus repeated Idx=0 captures. Required: the Idx=3 digit is never captured; the last Idx=0 value wins and the frame completes only after Idx 1 and 2 are captured.
